// File: rtl/struct_flag_fifo.sv
// rtl/struct_flag_fifo.sv - Depth-entry FIFO of 4-bit flag structs with output mask and hold register

package top_pkg;
    // Field a is the MSB, so '{a:1, b:0, c:1, d:0} reads as 4'b1010.
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } my_struct_t;
endpackage

module struct_flag_fifo #(
    parameter int                 Depth      = 4,
    parameter top_pkg::my_struct_t ResetValue = '{a: 1'b1, b: 1'b0, c: 1'b1, d: 1'b0},
    parameter top_pkg::my_struct_t Mask       = '{a: 1'b1, b: 1'b1, c: 1'b1, d: 1'b1}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  top_pkg::my_struct_t        in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output top_pkg::my_struct_t        out_data,
    output logic [2:0]                 out_ones,
    output logic [$clog2(Depth+1)-1:0] level,
    output logic [7:0]                 pop_count
);

    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = $clog2(Depth+1);

    top_pkg::my_struct_t mem [Depth];
    top_pkg::my_struct_t hold;
    top_pkg::my_struct_t head_masked;
    logic [PtrW-1:0]     wr_ptr;
    logic [PtrW-1:0]     rd_ptr;
    logic                push;
    logic                pop;

    // Handshake flags depend on registered occupancy only; a full FIFO refuses a push even during a pop.
    always_comb begin
        in_ready    = (level != LvlW'(Depth));
        out_valid   = (level != '0);
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
        head_masked = mem[rd_ptr] & Mask;
    end

    // Present the masked head while data is pending, otherwise the last delivered value.
    always_comb begin
        out_data = hold;
        if (out_valid) begin
            out_data = head_masked;
        end
        out_ones = {2'b00, out_data.a} + {2'b00, out_data.b}
                 + {2'b00, out_data.c} + {2'b00, out_data.d};
    end

    // Storage array is never cleared; reset only invalidates it through the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy, hold register and delivered-struct counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pop_count <= '0;
            hold      <= ResetValue;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PtrW'(1);
                hold      <= head_masked;
                pop_count <= pop_count + 8'd1;
            end
            if (push && !pop) begin
                level <= level + LvlW'(1);
            end else if (pop && !push) begin
                level <= level - LvlW'(1);
            end
        end
    end

endmodule

// File: tb/tb_struct_flag_fifo.sv
// tb/tb_struct_flag_fifo.sv - scoreboard and vector-table bench for struct_flag_fifo

module tb_struct_flag_fifo;

    localparam int DEPTH = 4;

    logic                clk;
    logic                rst;
    logic                iv;
    logic                ir;
    top_pkg::my_struct_t din;
    logic                ov;
    logic                ordy;
    top_pkg::my_struct_t dout;
    logic [2:0]          ones;
    logic [2:0]          lvl;
    logic [7:0]          pc;

    logic                m_iv;
    logic                m_ir;
    top_pkg::my_struct_t m_din;
    logic                m_ov;
    logic                m_ordy;
    top_pkg::my_struct_t m_dout;
    logic [2:0]          m_ones;
    logic [2:0]          m_lvl;
    logic [7:0]          m_pc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] q[$];
    logic [3:0] exp_hold;
    logic [7:0] exp_pops;

    struct_flag_fifo #(.Depth(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(iv), .in_ready(ir), .in_data(din),
        .out_valid(ov), .out_ready(ordy), .out_data(dout),
        .out_ones(ones), .level(lvl), .pop_count(pc)
    );

    struct_flag_fifo #(
        .Depth(DEPTH),
        .Mask('{a: 1'b1, b: 1'b0, c: 1'b1, d: 1'b0})
    ) dut_mask (
        .clk(clk), .rst(rst),
        .in_valid(m_iv), .in_ready(m_ir), .in_data(m_din),
        .out_valid(m_ov), .out_ready(m_ordy), .out_data(m_dout),
        .out_ones(m_ones), .level(m_lvl), .pop_count(m_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_hold = 4'b1010;
        exp_pops = 8'd0;
    endtask

    // One clock: compare DUT against the model at the negedge, update the model, step past the posedge.
    task automatic cycle();
        logic       do_push;
        logic       do_pop;
        logic [3:0] exp_data;
        @(negedge clk);
        exp_data = (q.size() != 0) ? q[0] : exp_hold;
        check("out_valid", 32'(ov), 32'(q.size() != 0));
        check("in_ready", 32'(ir), 32'(q.size() != DEPTH));
        check("level", 32'(lvl), 32'(q.size()));
        check("pop_count", 32'(pc), 32'(exp_pops));
        check("out_data", 32'(dout), 32'(exp_data));
        check("out_ones", 32'(ones), 32'($countones(exp_data)));
        do_push = iv && (q.size() != DEPTH);
        do_pop  = ordy && (q.size() != 0);
        if (do_pop) begin
            exp_hold = q.pop_front();
            exp_pops = exp_pops + 8'd1;
        end
        if (do_push) begin
            q.push_back(din);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       r;
        int         exp_level;
        logic       exp_ready;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 4'h1, 1'b0, 1, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 4'h2, 1'b0, 2, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 4'h4, 1'b0, 3, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 4'h8, 1'b0, 4, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 4'hF, 1'b0, 4, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 4'h0, 1'b1, 3, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 4'h0, 1'b1, 2, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 4'h0, 1'b1, 1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 4'h0, 1'b1, 0, 1'b1, 1'b0};

        rst = 1'b1; iv = 1'b0; din = '0; ordy = 1'b0;
        m_iv = 1'b0; m_din = '0; m_ordy = 1'b0;
        model_reset();
        #12;
        check("rst out_data", 32'(dout), 32'h a);
        check("rst out_ones", 32'(ones), 32'd2);
        check("rst out_valid", 32'(ov), 32'd0);
        check("rst in_ready", 32'(ir), 32'd1);
        check("rst level", 32'(lvl), 32'd0);
        check("rst pop_count", 32'(pc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single transfer with consumer stalled, then released.
        iv = 1'b1; din = 4'b0101; cycle();
        iv = 1'b0; din = '0;
        check("single out_valid", 32'(ov), 32'd1);
        check("single out_data", 32'(dout), 32'h5);
        check("single level", 32'(lvl), 32'd1);
        ordy = 1'b1; cycle();
        ordy = 1'b0;
        check("single after pop out_valid", 32'(ov), 32'd0);
        check("single held out_data", 32'(dout), 32'h5);
        check("single pop_count", 32'(pc), 32'd1);
        cycle();

        // Fill, overflow attempt and drain from the vector table.
        for (int i = 0; i < 9; i++) begin
            iv = vecs[i].v; din = vecs[i].d; ordy = vecs[i].r;
            cycle();
            check($sformatf("vec%0d level", i), 32'(lvl), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d in_ready", i), 32'(ir), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d out_valid", i), 32'(ov), 32'(vecs[i].exp_valid));
        end
        iv = 1'b0; ordy = 1'b0;
        check("drain held last", 32'(dout), 32'h8);
        check("drain pop_count", 32'(pc), 32'd5);

        // Streaming at level 2 for ten cycles with pointer wrap.
        iv = 1'b1; din = 4'h3; cycle();
        din = 4'h6; cycle();
        ordy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 4'(i + 7);
            cycle();
            check("stream level", 32'(lvl), 32'd2);
        end
        check("stream pop_count", 32'(pc), 32'd15);
        iv = 1'b0;
        cycle(); cycle();
        ordy = 1'b0;
        check("stream drained last", 32'(dout), 32'(4'(9 + 7)));
        check("stream final pop_count", 32'(pc), 32'd17);

        // Masked instance.
        m_iv = 1'b1; m_din = 4'hF; cycle();
        m_iv = 1'b0;
        check("mask out_data", 32'(m_dout), 32'ha);
        check("mask out_ones", 32'(m_ones), 32'd2);
        check("mask out_valid", 32'(m_ov), 32'd1);

        // Reset at level 3, asserted away from the clock edge.
        iv = 1'b1; din = 4'h9; cycle();
        din = 4'hC; cycle();
        din = 4'h5; cycle();
        iv = 1'b0;
        check("pre-reset level", 32'(lvl), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst level", 32'(lvl), 32'd0);
        check("midrst out_data", 32'(dout), 32'ha);
        check("midrst out_ones", 32'(ones), 32'd2);
        check("midrst out_valid", 32'(ov), 32'd0);
        check("midrst in_ready", 32'(ir), 32'd1);
        check("midrst pop_count", 32'(pc), 32'd0);
        check("midrst mask out_data", 32'(m_dout), 32'ha);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        iv = 1'b1; din = 4'h3; cycle();
        iv = 1'b0;
        check("post-reset out_data", 32'(dout), 32'h3);
        check("post-reset level", 32'(lvl), 32'd1);
        ordy = 1'b1; cycle();
        ordy = 1'b0;
        check("post-reset empty", 32'(ov), 32'd0);
        check("post-reset pop_count", 32'(pc), 32'd1);

        // 256 further pops wrap pop_count back to 1.
        iv = 1'b1; din = 4'hA; cycle();
        ordy = 1'b1;
        for (int i = 0; i < 255; i++) begin
            din = 4'(i);
            cycle();
        end
        iv = 1'b0;
        cycle();
        ordy = 1'b0;
        check("wrap pop_count", 32'(pc), 32'd1);
        check("wrap level", 32'(lvl), 32'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/struct_flag_fifo.md
# struct_flag_fifo

Buffering stage downstream of the `top_pkg::my_struct_t` producer. It accepts one 4-bit flag struct (`a`, `b`, `c`, `d`) per handshake into a Depth-entry FIFO and presents the head entry to the consumer with a compile-time field mask applied. When no entry is pending, it holds the last delivered struct, which after reset is the struct-typed parameter `ResetValue`. It also reports fill level, a popcount of the presented flags, and a wrapping count of delivered structs.

## Interface
Parameters:
- `Depth`, 4, FIFO entries; power of two, ≥ 2.
- `ResetValue`, `top_pkg::my_struct_t`, `'{a:1'b1, b:1'b0, c:1'b1, d:1'b0}`, presented value after reset and before the first pop.
- `Mask`, `top_pkg::my_struct_t`, `'{a:1'b1, b:1'b1, c:1'b1, d:1'b1}`, field-wise AND applied to the FIFO head on output.

Ports:
- `clk`  in  1  Sole clock; all state on rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `in_valid`  in  1  Upstream struct valid.
- `in_ready`  out  1  FIFO can accept.
- `in_data`  in  4 (`top_pkg::my_struct_t`)  Upstream struct.
- `out_valid`  out  1  Head entry available.
- `out_ready`  in  1  Consumer accepts.
- `out_data`  out  4 (`top_pkg::my_struct_t`)  Masked head when `out_valid`, otherwise the held last value.
- `out_ones`  out  3  Number of set fields in `out_data` (0–4).
- `level`  out  `$clog2(Depth+1)`  Current occupancy.
- `pop_count`  out  8  Delivered structs, wraps 255→0.

## Operation
- Storage: Depth × 4-bit array, write pointer `wr_ptr`, read pointer `rd_ptr`, each `$clog2(Depth)` bits, wrapping Depth-1→0. Occupancy counter `level` runs 0..Depth.
- Push = `in_valid && in_ready`; writes `in_data` at `wr_ptr` and increments `wr_ptr`.
- Pop = `out_valid && out_ready`; increments `rd_ptr`, loads `hold` with the masked head, and increments `pop_count`.
- `in_ready = (level != Depth)`. It is registered-state only and does not depend on `out_ready`. When full, no push is accepted, even if a pop occurs in the same cycle.
- `out_valid = (level != 0)`.
- `out_data`:
  - when `out_valid`, `mem[rd_ptr] & Mask`, applied field-wise;
  - otherwise `hold`.
- `out_ones` is the combinational popcount of `out_data` fields.
- Level update:
  - push only: +1;
  - pop only: −1;
  - push and pop together (possible only when 0 < level < Depth): unchanged.
- Push while empty: the entry becomes visible on the next cycle, not bypassed.
- Masking applies on output only; stored data is unmasked.
- Reset (asynchronous, any cycle, including mid-transfer):
  - `wr_ptr`, `rd_ptr`, `level`, `pop_count` ← 0;
  - `hold` ← `ResetValue`;
  - FIFO contents are not cleared and are not observable.
  - Outputs during and after reset: `in_ready`=1, `out_valid`=0, `out_data`=`ResetValue`, `out_ones`=`popcount(ResetValue)`, `level`=0, `pop_count`=0.
  - Note: `ResetValue` is not masked.

## Timing
- Latency: push at edge N → `out_valid`=1 and the entry at head during cycle N+1, i.e. one cycle minimum.
- Throughput: one push and one pop per cycle sustained while 0 < level < Depth.
- `in_ready` and `out_valid` are functions of registered state only; there are no combinational paths from input to output except `out_data` → `out_ones`.
- After a pop of the last entry, `out_data` shows the same masked value (now from `hold`) with `out_valid`=0 on the next cycle.
- `pop_count` and `level` update on the same edge as the handshake.
- Upstream must hold `in_data` stable while `in_valid && !in_ready`. The block itself tolerates `in_valid` dropping without a transfer.

## Test plan
- Reset check: assert `rst` mid-cycle → immediately `out_data`=4'b1010 (a=1, b=0, c=1, d=0), `out_ones`=2, `out_valid`=0, `in_ready`=1, `level`=0.
- Single transfer, `out_ready`=0: push `'{a:0, b:1, c:0, d:1}` → next cycle `out_valid`=1, `out_data`=4'b0101, `level`=1. Raise `out_ready` → after the pop, `out_valid`=0, `out_data` holds 4'b0101, `pop_count`=1.
- Fill and overflow attempt, `out_ready`=0: push 4'h1, 2, 4, 8 → `level`=4, `in_ready`=0. A fifth push of 4'hF is not accepted. Drain → order is 1, 2, 4, 8, then `level`=0.
- Simultaneous push/pop at level 2 for 10 cycles: `level` stays 2, data arrives in order, `pop_count`=10. Pointers wrap with no loss.
- Mask with `Mask`=`'{a:1, b:0, c:1, d:0}`: push 4'hF → `out_data`=4'b1010, `out_ones`=2.
- Reset with `level`=3 → `level`=0, `out_data`=`ResetValue`. A subsequent push of 4'h3 yields `out_data`=4'h3, with no stale entries.
- Additional check: 256 pops → `pop_count` wraps to 0.
